// File: rtl/rtc_cmd_core_if.sv
// Byte-level link between the SPI slave and the RTC command core.
// master: SPI slave side (drives rx bytes, halt, abort); slave: core side (drives tx).
interface rtc_cmd_core_if;
   logic [7:0] rx_data;
   logic       rx_dv;
   logic       tx_halt;
   logic       frame_abort;
   logic [7:0] tx_data;
   logic       tx_wr;

   modport master (
      output rx_data, rx_dv, tx_halt, frame_abort,
      input  tx_data, tx_wr
   );

   modport slave (
      input  rx_data, rx_dv, tx_halt, frame_abort,
      output tx_data, tx_wr
   );
endinterface

// File: rtl/rtc_cmd_core.sv
// RTC command/register core: epoch counter, alarm compares, SPI byte command FSM.
// Ports: clk, rst (sync, active-high), one_hz, count_enable, bus (SPI byte link),
//        epoch, alarm (sticky flags), alarm_irq, busy.
module rtc_cmd_core #(
   parameter int EPOCH_BYTES = 8,
   parameter int NUM_ALARMS  = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     one_hz,
   input  logic                     count_enable,
   rtc_cmd_core_if.slave            bus,
   output logic [8*EPOCH_BYTES-1:0] epoch,
   output logic [NUM_ALARMS-1:0]    alarm,
   output logic                     alarm_irq,
   output logic                     busy
);
   localparam int W = 8 * EPOCH_BYTES;
   localparam logic [4:0] LAST = 5'(EPOCH_BYTES - 1);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] WR_BYTES = 3'd1;
   localparam logic [2:0] RD_LOAD  = 3'd2;
   localparam logic [2:0] RD_WAIT  = 3'd3;
   localparam logic [2:0] DISCARD  = 3'd4;

   logic [2:0]            state_q, state_d;
   logic [4:0]            cnt_q, cnt_d;
   logic [2:0]            idx_q, idx_d;
   logic [W-1:0]          shadow_q, shadow_d;
   logic [W-1:0]          epoch_q, epoch_d;
   logic [W-1:0]          alm_q [NUM_ALARMS];
   logic [W-1:0]          alm_d [NUM_ALARMS];
   logic [NUM_ALARMS-1:0] alarm_q, alarm_d;
   logic [NUM_ALARMS-1:0] clr_q, clr_d;
   logic                  upd_q, upd_d;
   logic [7:0]            tx_data_q, tx_data_d;
   logic                  tx_wr_q, tx_wr_d;

   logic [W-1:0]          sh_in;
   logic [W-1:0]          rd_sel;
   logic                  idx_ok;
   logic                  commit;

   // Shadow with the incoming byte appended (MSB-first).
   always_comb begin
      sh_in  = (shadow_q << 8) | W'(bus.rx_data);
      idx_ok = bus.rx_data[5:0] <= 6'(NUM_ALARMS);
      rd_sel = epoch_q;
      for (int k = 0; k < NUM_ALARMS; k++) begin
         if (bus.rx_data[5:0] == 6'(k + 1)) rd_sel = alm_q[k];
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      shadow_d  = shadow_q;
      epoch_d   = epoch_q;
      alm_d     = alm_q;
      clr_d     = '0;
      upd_d     = 1'b0;
      tx_data_d = tx_data_q;
      tx_wr_d   = 1'b0;
      commit    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.rx_dv) begin
               unique case (bus.rx_data[7:6])
                  2'b01: begin
                     cnt_d   = '0;
                     idx_d   = bus.rx_data[2:0];
                     state_d = idx_ok ? WR_BYTES : DISCARD;
                  end
                  2'b10: begin
                     cnt_d    = '0;
                     shadow_d = rd_sel;
                     state_d  = idx_ok ? RD_LOAD : DISCARD;
                  end
                  2'b11: clr_d = bus.rx_data[NUM_ALARMS-1:0];
                  2'b00: ;
               endcase
            end
         end
         WR_BYTES: begin
            if (bus.rx_dv) begin
               shadow_d = sh_in;
               cnt_d    = cnt_q + 5'd1;
               if (cnt_q == LAST) begin
                  commit  = 1'b1;
                  state_d = IDLE;
                  if (idx_q == 3'd0) begin
                     epoch_d = sh_in;
                     upd_d   = 1'b1;
                  end
                  for (int k = 0; k < NUM_ALARMS; k++) begin
                     if (int'(idx_q) == k + 1) alm_d[k] = sh_in;
                  end
               end
            end
         end
         RD_LOAD: begin
            if (!bus.tx_halt) begin
               tx_data_d = shadow_q[W-1 -: 8];
               tx_wr_d   = 1'b1;
               state_d   = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (bus.rx_dv) begin
               shadow_d = shadow_q << 8;
               cnt_d    = cnt_q + 5'd1;
               state_d  = (cnt_q == LAST) ? IDLE : RD_LOAD;
            end
         end
         DISCARD: ;
         default: state_d = IDLE;
      endcase

      // Abort drops whatever the byte path was doing, including a commit.
      if (bus.frame_abort) begin
         state_d = IDLE;
         tx_wr_d = 1'b0;
         commit  = 1'b0;
         epoch_d = epoch_q;
         alm_d   = alm_q;
         clr_d   = '0;
         upd_d   = 1'b0;
      end

      // A commit to any register swallows a coincident tick.
      if (one_hz && count_enable && !commit) begin
         epoch_d = epoch_q + 1'b1;
         upd_d   = 1'b1;
      end

      // Compare runs on the registered epoch; set beats clear.
      for (int k = 0; k < NUM_ALARMS; k++) begin
         alarm_d[k] = (alarm_q[k] & ~clr_q[k]) |
                      (upd_q & (epoch_q == alm_q[k]));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         shadow_q  <= '0;
         epoch_q   <= '0;
         for (int k = 0; k < NUM_ALARMS; k++) alm_q[k] <= '1;
         alarm_q   <= '0;
         clr_q     <= '0;
         upd_q     <= 1'b0;
         tx_data_q <= '0;
         tx_wr_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shadow_q  <= shadow_d;
         epoch_q   <= epoch_d;
         alm_q     <= alm_d;
         alarm_q   <= alarm_d;
         clr_q     <= clr_d;
         upd_q     <= upd_d;
         tx_data_q <= tx_data_d;
         tx_wr_q   <= tx_wr_d;
      end
   end

   assign bus.tx_data = tx_data_q;
   assign bus.tx_wr   = tx_wr_q;
   assign epoch       = epoch_q;
   assign alarm       = alarm_q;
   assign alarm_irq   = |alarm_q;
   assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_rtc_cmd_core.sv
// Directed bench for rtc_cmd_core (EPOCH_BYTES=8, NUM_ALARMS=2).
// Table of write/tick/readback vectors plus hand sequences for corner cases.
module tb_rtc_cmd_core;
   logic        clk;
   logic        rst;
   logic        one_hz;
   logic        count_enable;
   logic [63:0] epoch;
   logic [1:0]  alarm;
   logic        alarm_irq;
   logic        busy;

   int total_cnt = 0;
   int pass_cnt  = 0;
   int txwr_cnt  = 0;

   rtc_cmd_core_if bus ();

   rtc_cmd_core #(.EPOCH_BYTES(8), .NUM_ALARMS(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .one_hz       (one_hz),
      .count_enable (count_enable),
      .bus          (bus),
      .epoch        (epoch),
      .alarm        (alarm),
      .alarm_irq    (alarm_irq),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (bus.tx_wr) txwr_cnt++;

   typedef struct {
      logic [63:0] wr;
      int          ticks;
      logic        ce;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rx_data = b;
      bus.rx_dv   = 1'b1;
      tick();
      bus.rx_dv   = 1'b0;
   endtask

   task automatic wr_reg(input logic [7:0] cmd, input logic [63:0] v);
      send_byte(cmd);
      for (int i = 0; i < 8; i++) send_byte(v[63-8*i -: 8]);
   endtask

   task automatic wait_txwr();
      int n;
      n = 0;
      while (!bus.tx_wr && n < 20) begin
         tick();
         n++;
      end
      chk("tx_wr wait", bus.tx_wr, 1);
   endtask

   task automatic rd_reg(input logic [7:0] cmd, output logic [63:0] v);
      v = '0;
      send_byte(cmd);
      for (int i = 0; i < 8; i++) begin
         wait_txwr();
         v = {v[55:0], bus.tx_data};
         send_byte(8'h00);
      end
   endtask

   task automatic pulse_hz(input logic ce);
      one_hz       = 1'b1;
      count_enable = ce;
      tick();
      one_hz       = 1'b0;
      count_enable = 1'b0;
      tick();
   endtask

   initial begin
      logic [63:0] rv;
      logic [63:0] ev;
      int          t0;

      vecs[0] = '{64'h0000_0000_0000_0100, 0, 1'b0, 64'h0000_0000_0000_0100};
      vecs[1] = '{64'h0123_4567_89AB_CDEF, 0, 1'b0, 64'h0123_4567_89AB_CDEF};
      vecs[2] = '{64'h0000_0000_FFFF_FFFF, 1, 1'b1, 64'h0000_0001_0000_0000};
      vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 2, 1'b1, 64'h0000_0000_0000_0001};
      vecs[4] = '{64'h0000_0000_0000_00FF, 2, 1'b0, 64'h0000_0000_0000_00FF};

      rst             = 1'b1;
      one_hz          = 1'b0;
      count_enable    = 1'b0;
      bus.rx_data     = 8'h00;
      bus.rx_dv       = 1'b0;
      bus.tx_halt     = 1'b0;
      bus.frame_abort = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();

      chk("rst epoch", epoch, 0);
      chk("rst alarm", alarm, 0);
      chk("rst irq", alarm_irq, 0);
      chk("rst tx_wr", bus.tx_wr, 0);
      chk("rst tx_data", bus.tx_data, 0);
      chk("rst busy", busy, 0);

      // Epoch write: value appears, busy drops, right after the 8th byte.
      send_byte(8'h40);
      for (int i = 0; i < 7; i++) send_byte(i == 6 ? 8'h01 : 8'h00);
      chk("wr busy mid", busy, 1);
      chk("wr epoch mid", epoch, 0);
      send_byte(8'h00);
      chk("wr epoch", epoch, 64'h100);
      chk("wr busy end", busy, 0);

      // Wrap through all ones.
      wr_reg(8'h40, 64'hFFFF_FFFF_FFFF_FFFE);
      one_hz       = 1'b1;
      count_enable = 1'b1;
      tick();
      chk("wrap ff", epoch, 64'hFFFF_FFFF_FFFF_FFFF);
      tick();
      chk("wrap 0", epoch, 0);
      tick();
      chk("wrap 1", epoch, 1);
      one_hz       = 1'b0;
      count_enable = 1'b0;
      tick();

      for (int v = 0; v < 5; v++) begin
         wr_reg(8'h40, vecs[v].wr);
         for (int t = 0; t < vecs[v].ticks; t++) pulse_hz(vecs[v].ce);
         chk($sformatf("vec%0d epoch", v), epoch, vecs[v].exp);
         rd_reg(8'h80, rv);
         chk($sformatf("vec%0d read", v), rv, vecs[v].exp);
      end

      // Alarm 0 at 5: flags were set by the all-ones wrap, clear first.
      wr_reg(8'h41, 64'd5);
      send_byte(8'hC3);
      tick();
      chk("alm clr all", alarm, 0);
      wr_reg(8'h40, 64'd3);
      tick();
      chk("alm after wr", alarm, 0);
      pulse_hz(1'b1);
      one_hz       = 1'b1;
      count_enable = 1'b1;
      tick();
      one_hz       = 1'b0;
      count_enable = 1'b0;
      chk("alm epoch5", epoch, 5);
      chk("alm not yet", alarm, 0);
      tick();
      chk("alm set", alarm, 2'b01);
      chk("alm irq", alarm_irq, 1);
      send_byte(8'hC1);
      chk("alm still", alarm, 2'b01);
      tick();
      chk("alm cleared", alarm, 0);
      chk("alm irq off", alarm_irq, 0);

      // Read stalled by tx_halt, with a tick mid-read.
      wr_reg(8'h40, 64'h0123_4567_89AB_CDEF);
      ev = 64'h0123_4567_89AB_CDEF;
      bus.tx_halt = 1'b1;
      send_byte(8'h80);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("halt no wr", bus.tx_wr, 0);
      end
      bus.tx_halt = 1'b0;
      for (int i = 0; i < 8; i++) begin
         wait_txwr();
         chk($sformatf("rd byte%0d", i), bus.tx_data, ev[63-8*i -: 8]);
         if (i == 0) begin
            one_hz       = 1'b1;
            count_enable = 1'b1;
         end
         send_byte(8'h00);
         one_hz       = 1'b0;
         count_enable = 1'b0;
      end
      chk("rd busy end", busy, 0);
      chk("rd epoch tick", epoch, 64'h0123_4567_89AB_CDF0);

      // Abort coincident with the 4th data byte.
      send_byte(8'h40);
      for (int i = 0; i < 3; i++) send_byte(8'hAA);
      bus.rx_data     = 8'hAA;
      bus.rx_dv       = 1'b1;
      bus.frame_abort = 1'b1;
      tick();
      bus.rx_dv       = 1'b0;
      bus.frame_abort = 1'b0;
      chk("abort busy", busy, 0);
      for (int i = 0; i < 5; i++) tick();
      chk("abort epoch", epoch, 64'h0123_4567_89AB_CDF0);

      // Invalid index: everything dropped until abort.
      t0 = txwr_cnt;
      send_byte(8'h7F);
      chk("inv busy", busy, 1);
      send_byte(8'h80);
      send_byte(8'h41);
      send_byte(8'hC3);
      send_byte(8'h01);
      tick();
      tick();
      chk("inv busy hold", busy, 1);
      chk("inv no tx_wr", txwr_cnt - t0, 0);
      chk("inv epoch", epoch, 64'h0123_4567_89AB_CDF0);
      bus.frame_abort = 1'b1;
      tick();
      bus.frame_abort = 1'b0;
      chk("inv abort busy", busy, 0);
      rd_reg(8'h80, rv);
      chk("inv then read", rv, 64'h0123_4567_89AB_CDF0);
      rd_reg(8'h81, rv);
      chk("alarm0 read", rv, 64'd5);

      // Commit swallows a coincident tick; commit itself arms the compare.
      send_byte(8'h40);
      for (int i = 0; i < 7; i++) send_byte(8'h00);
      one_hz       = 1'b1;
      count_enable = 1'b1;
      send_byte(8'h05);
      one_hz       = 1'b0;
      count_enable = 1'b0;
      chk("commit vs tick", epoch, 5);
      tick();
      chk("commit alarm", alarm, 2'b01);
      chk("commit epoch hold", epoch, 5);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
